// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch stage between the PC register and decode.
// Optional macro IF_TIMEOUT_EN adds a bounded WAIT with a sticky fetch_err.
module inst_fetch_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_wre,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              misalign,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_ir;
    logic                r_ir_valid;
    logic                r_misalign;
    logic                r_drop;

    logic                w_misal;
    logic                w_mem_req;
    logic                w_pc_wre;
    logic                w_ld_data;
    logic                w_ld_nop;
    logic                w_ld_err;
    logic                w_set_drop;
    logic                w_tout;

    assign w_misal = (pc_addr[1:0] != 2'b00);

`ifdef IF_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_timer;
    logic          r_err;

    assign w_tout    = (r_timer == TW'(TIMEOUT - 1));
    assign fetch_err = r_err;

    // Count consecutive WAIT cycles; restart whenever WAIT is left.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (r_state == S_WAIT && w_state_nxt == S_WAIT) begin
            r_timer <= r_timer + TW'(1);
        end else begin
            r_timer <= '0;
        end
    end

    // Sticky timeout flag, cleared only by flush or reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (flush) begin
            r_err <= 1'b0;
        end else if (w_ld_err) begin
            r_err <= 1'b1;
        end
    end
`else
    // Without the timer WAIT is unbounded; the term keeps TIMEOUT referenced.
    assign w_tout    = 1'b0 && (TIMEOUT > 0);
    assign fetch_err = 1'b0;
`endif

    // Next-state and handshake decode; flush always wins over ready/rvalid.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        w_pc_wre    = 1'b0;
        w_ld_data   = 1'b0;
        w_ld_nop    = 1'b0;
        w_ld_err    = 1'b0;
        w_set_drop  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (flush) begin
                    w_state_nxt = S_REQ;
                end else if (w_misal) begin
                    w_ld_nop    = 1'b1;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_mem_req = 1'b1;
                    if (mem_gnt) begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    // A response in the flush cycle is simply discarded.
                    if (mem_rvalid) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_set_drop = 1'b1;
                    end
                end else if (mem_rvalid) begin
                    if (r_drop) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_ld_data   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (w_tout) begin
                    w_ld_err    = 1'b1;
                    w_set_drop  = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    w_state_nxt = S_REQ;
                end else if (ir_ready) begin
                    w_pc_wre    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset also aborts any in-flight fetch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Remember the granted address so mem_addr stays defined outside REQ.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr <= '0;
        end else if (w_mem_req && mem_gnt) begin
            r_addr <= pc_addr;
        end
    end

    // Instruction register and its valid bit toward decode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else if (flush) begin
            r_ir_valid <= 1'b0;
        end else if (w_ld_data) begin
            r_ir       <= mem_rdata;
            r_ir_valid <= 1'b1;
        end else if (w_ld_nop || w_ld_err) begin
            r_ir       <= '0;
            r_ir_valid <= 1'b1;
        end else if (w_pc_wre) begin
            r_ir_valid <= 1'b0;
        end
    end

    // Sticky misalignment flag, cleared only by flush or reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_misalign <= 1'b0;
        end else if (flush) begin
            r_misalign <= 1'b0;
        end else if (w_ld_nop) begin
            r_misalign <= 1'b1;
        end
    end

    // Drop marker: the next response belongs to an abandoned fetch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_drop <= 1'b0;
        end else if (w_set_drop) begin
            r_drop <= 1'b1;
        end else if (r_drop && mem_rvalid) begin
            r_drop <= 1'b0;
        end
    end

    assign mem_req  = reset & w_mem_req;
    assign pc_wre   = reset & w_pc_wre;
    assign mem_addr = (r_state == S_REQ) ? pc_addr : r_addr;
    assign ir       = r_ir;
    assign ir_valid = r_ir_valid;
    assign misalign = r_misalign;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed scenarios, then random traffic
// checked against a PC/memory/decode reference model.
module tb_inst_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc_addr;
    logic        pc_wre;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic        misalign;
    logic        fetch_err;

    int n_chk;
    int n_fail;

    inst_fetch_unit #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_addr   (pc_addr),
        .pc_wre    (pc_wre),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .misalign  (misalign),
        .fetch_err (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory image seen by the model: a fixed hash of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] exp_ir(input logic [31:0] pc);
        if (pc[1:0] != 2'b00) return 32'h0;
        return mem_word(pc);
    endfunction

    logic        pend;
    logic [31:0] pend_addr;
    int          lat;
    int          consumes;
    logic        exp_wre;

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        reset      = 1'b0;
        pc_addr    = 32'h18c;
        flush      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        ir_ready   = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ir", ir, 0);
        chk("rst_irv", ir_valid, 0);
        chk("rst_mis", misalign, 0);
        chk("rst_err", fetch_err, 0);
        chk("rst_wre", pc_wre, 0);
        reset = 1'b1;
        #1;
        chk("idle_req", mem_req, 0);

        // first request, gnt same cycle, rvalid next, consume
        @(negedge clk);
        #1;
        chk("req1", mem_req, 1);
        chk("req1_addr", mem_addr, 32'h18c);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h2001_0005;
        #1;
        chk("wait_req", mem_req, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        ir_ready   = 1'b1;
        #1;
        chk("t2_ir", ir, 32'h2001_0005);
        chk("t2_irv", ir_valid, 1);
        chk("t2_wre", pc_wre, 1);
        @(posedge clk);
        #1 pc_addr = 32'h190;
        @(negedge clk);
        ir_ready = 1'b0;
        #1;
        chk("t2_wre_off", pc_wre, 0);
        chk("t2_irv_off", ir_valid, 0);
        chk("t2_req", mem_req, 1);
        chk("t2_addr", mem_addr, 32'h190);

        // decode stalls for 5 cycles in HOLD
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_ir", ir, 32'h1111_1111);
            chk("t3_wre", pc_wre, 0);
            chk("t3_req", mem_req, 0);
            @(negedge clk);
        end
        ir_ready = 1'b1;
        #1;
        chk("t3_wre_go", pc_wre, 1);
        @(posedge clk);
        #1 pc_addr = 32'h18e;

        // misaligned PC: NOP without a request
        @(negedge clk);
        ir_ready = 1'b0;
        #1;
        chk("t4_req_a", mem_req, 0);
        @(negedge clk);
        #1;
        chk("t4_mis", misalign, 1);
        chk("t4_ir", ir, 0);
        chk("t4_irv", ir_valid, 1);
        chk("t4_req_b", mem_req, 0);
        flush = 1'b1;
        #1;
        chk("t4_flush_wre", pc_wre, 0);
        @(posedge clk);
        #1 pc_addr = 32'h200;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("t4_mis_clr", misalign, 0);
        chk("t4_irv_clr", ir_valid, 0);
        chk("t4_req_c", mem_req, 1);
        chk("t4_addr", mem_addr, 32'h200);

        // flush during WAIT: stale response discarded
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        flush   = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        pc_addr = 32'h300;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("t5_irv", ir_valid, 0);
        chk("t5_req", mem_req, 1);
        chk("t5_addr", mem_addr, 32'h300);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_0001;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("t5_ir", ir, 32'hCAFE_0001);
        chk("t5_irv2", ir_valid, 1);
        flush = 1'b1;
        @(posedge clk);
        #1 pc_addr = 32'h400;

        // reset mid-WAIT: late response ignored
        @(negedge clk);
        flush   = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        reset      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("t6_irv", ir_valid, 0);
        chk("t6_ir", ir, 0);
        chk("t6_req", mem_req, 1);
        chk("t6_addr", mem_addr, 32'h400);

`ifdef IF_TIMEOUT_EN
        // no response: fault after 4 WAIT cycles
        mem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_gnt = 1'b0;
            #1;
            chk("to_early", fetch_err, 0);
        end
        @(negedge clk);
        #1;
        chk("to_err", fetch_err, 1);
        chk("to_ir", ir, 0);
        chk("to_irv", ir_valid, 1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        flush      = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("to_clr", fetch_err, 0);
        chk("to_req", mem_req, 1);
`endif

        // random traffic against the reference model
        pend     = 1'b0;
        lat      = 0;
        consumes = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            #1;
            if (ir_valid) begin
                chk("r_ir", ir, exp_ir(pc_addr));
                chk("r_mis", misalign, pc_addr[1:0] != 2'b00);
            end
            chk("r_err", fetch_err, 0);
            flush    = ($urandom_range(0, 19) == 0);
            ir_ready = ($urandom_range(0, 2) != 0);
            mem_gnt  = 1'b0;
            mem_rvalid = 1'b0;
            if (pend) begin
                if (lat == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word(pend_addr);
                    pend       = 1'b0;
                end else begin
                    lat--;
                end
            end
            #1;
            if (mem_req) begin
                chk("r_addr", mem_addr, pc_addr);
                chk("r_align", pc_addr[1:0], 0);
                if (!pend && $urandom_range(0, 1) == 1) begin
                    mem_gnt   = 1'b1;
                    pend      = 1'b1;
                    pend_addr = mem_addr;
                    lat       = $urandom_range(0, 2);
                end
            end
            exp_wre = ir_valid && ir_ready && !flush;
            chk("r_wre", pc_wre, exp_wre);
            @(posedge clk);
            #1;
            if (flush) begin
                pc_addr = $urandom() & 32'h0000_FFFC;
                if ($urandom_range(0, 3) == 0)
                    pc_addr[1:0] = 2'($urandom_range(1, 3));
            end else if (exp_wre) begin
                pc_addr = pc_addr + 32'd4;
                consumes++;
            end
        end
        flush    = 1'b0;
        mem_gnt  = 1'b0;
        ir_ready = 1'b0;
        n_chk++;
        if (consumes < 100) begin
            n_fail++;
            $display("FAIL progress got=%0d exp>=100", consumes);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
